// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the axis-total derivation and the scan phase type.
package vga_pkg;

  localparam int unsigned COUNT_W = 10;

  // 640x480 @ 60 Hz with a 25 MHz pixel rate
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    PhaseActive,
    PhaseFront,
    PhaseSync,
    PhaseBack
  } phase_e;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle produced by vga_sync_gen; master drives, slave consumes.
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic               pixelTick;
  logic               hSync;
  logic               vSync;
  logic               videoOn;
  logic [COUNT_W-1:0] pixelX;
  logic [COUNT_W-1:0] pixelY;
  logic               frameStart;

  modport master (
    output pixelTick, hSync, vSync, videoOn, pixelX, pixelY, frameStart
  );

  modport slave (
    input pixelTick, hSync, vSync, videoOn, pixelX, pixelY, frameStart
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus combinational phase decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned Active = H_ACTIVE_DEF,
  parameter int unsigned Fp     = H_FP_DEF,
  parameter int unsigned Sync   = H_SYNC_DEF,
  parameter int unsigned Bp     = H_BP_DEF
) (
  input  logic               inClk,
  input  logic               reset,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output phase_e             phase
);

  localparam int unsigned Total = axis_total(Active, Fp, Sync, Bp);

  localparam logic [COUNT_W-1:0] LastCount  = COUNT_W'(Total - 1);
  localparam logic [COUNT_W-1:0] FrontStart = COUNT_W'(Active);
  localparam logic [COUNT_W-1:0] SyncStart  = COUNT_W'(Active + Fp);
  localparam logic [COUNT_W-1:0] BackStart  = COUNT_W'(Active + Fp + Sync);

  // High on the edge that takes the counter from its last value back to zero
  assign wrap = enable && (count == LastCount);

  always_ff @(posedge inClk) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNT_W'(1);
    end
  end

  always_comb begin
    phase = PhaseBack;
    if (count < FrontStart) begin
      phase = PhaseActive;
    end else if (count < SyncStart) begin
      phase = PhaseFront;
    end else if (count < BackStart) begin
      phase = PhaseSync;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator; define VGA_SYNC_FRAME_PULSE_EN to enable the
// one-cycle frameStart pulse (otherwise frameStart is tied low).
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic           inClk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  logic               tick;
  logic               hWrap;
  logic               vWrap;
  logic [COUNT_W-1:0] hCount;
  logic [COUNT_W-1:0] vCount;
  phase_e             hPhase;
  phase_e             vPhase;

  // Divides inClk by two to give the pixel-rate enable
  always_ff @(posedge inClk) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= ~tick;
    end
  end

  vga_axis_counter #(
    .Active(H_ACTIVE),
    .Fp    (H_FP),
    .Sync  (H_SYNC),
    .Bp    (H_BP)
  ) uHoriz (
    .inClk (inClk),
    .reset (reset),
    .enable(tick),
    .count (hCount),
    .wrap  (hWrap),
    .phase (hPhase)
  );

  // hWrap already includes tick, so the vertical axis steps once per line
  vga_axis_counter #(
    .Active(V_ACTIVE),
    .Fp    (V_FP),
    .Sync  (V_SYNC),
    .Bp    (V_BP)
  ) uVert (
    .inClk (inClk),
    .reset (reset),
    .enable(hWrap),
    .count (vCount),
    .wrap  (vWrap),
    .phase (vPhase)
  );

  assign vga.pixelTick = tick;
  assign vga.hSync     = (hPhase != PhaseSync);
  assign vga.vSync     = (vPhase != PhaseSync);
  assign vga.videoOn   = (hPhase == PhaseActive) && (vPhase == PhaseActive);
  assign vga.pixelX    = hCount;
  assign vga.pixelY    = vCount;

`ifdef VGA_SYNC_FRAME_PULSE_EN
  logic frameStartReg;

  // Set on the edge where both axes wrap, so it is high during the first cycle at (0,0)
  always_ff @(posedge inClk) begin
    if (reset) begin
      frameStartReg <= 1'b0;
    end else begin
      frameStartReg <= vWrap;
    end
  end

  assign vga.frameStart = frameStartReg;
`else
  logic unusedVWrap;
  assign unusedVWrap    = vWrap;
  assign vga.frameStart = 1'b0;
`endif

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical equivalents, in lines.
REQ-006 inClk  input  1: single 50 MHz system clock; all logic on its rising edge.
REQ-007 reset  input  1: synchronous, active-high reset.
REQ-008 pixelTick  output  1: pixel-rate enable; high every second inClk cycle (25 MHz).
REQ-009 hSync  output  1: horizontal sync, active low.
REQ-010 vSync  output  1: vertical sync, active low.
REQ-011 videoOn  output  1: high while in the visible region.
REQ-012 pixelX  output  10: current horizontal count (0..H_TOTAL-1).
REQ-013 pixelY  output  10: current vertical count (0..V_TOTAL-1).
REQ-014 frameStart  output  1: one-inClk pulse at the start of each frame.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); both computed at elaboration.
REQ-016 Internal tick register toggles every inClk cycle; pixelTick equals the tick register.
REQ-017 hCount increments only on edges where pixelTick==1; it holds on all other edges.
REQ-018 hCount==H_TOTAL-1 with pixelTick==1: hCount->0, and vCount increments.
REQ-019 hCount==H_TOTAL-1 and vCount==V_TOTAL-1 with pixelTick==1: both counters->0 on the same edge.
REQ-020 Horizontal phase FSM: ACTIVE (0..639) -> FRONT (640..655) -> SYNC (656..751) -> BACK (752..799) -> ACTIVE; state derived from hCount.
REQ-021 Vertical phase FSM: same four states over vCount (0..479, 480..489, 490..491, 492..524).
REQ-022 hSync is low iff horizontal state is SYNC; vSync is low iff vertical state is SYNC.
REQ-023 videoOn is high iff both the horizontal and vertical states are ACTIVE.
REQ-024 pixelX and pixelY are the counter registers, zero-extended to 10 bits; never out of range.
REQ-025 All outputs decode combinationally from registered state; zero latency relative to the counters.

Reset
REQ-026 While reset is high: tick=0, hCount=0, vCount=0, frameStart=0; reset takes priority over every other event.
REQ-027 Output values while in reset: pixelTick=0, hSync=1, vSync=1, videoOn=1, pixelX=0, pixelY=0.
REQ-028 Reset asserted mid-frame returns all state to REQ-026 on the next edge; no partial line completes.
REQ-029 First inClk edge after reset deasserts: pixelTick=1; counters advance on the following edge.

Configuration
REQ-030 Macro VGA_SYNC_FRAME_PULSE_EN defined: frameStart goes high for exactly one inClk cycle, on the cycle after both counters wrap to 0 (REQ-019).
REQ-031 Macro VGA_SYNC_FRAME_PULSE_EN undefined: frameStart is tied to 0 and no pulse logic is synthesised; port list is unchanged.

Structure
REQ-032 Shared package vga_pkg holds the default timing constants, the H_TOTAL/V_TOTAL derivations, and the phase enum (ACTIVE, FRONT, SYNC, BACK).
REQ-033 One sub-module, vga_axis_counter: a parameterised counter plus phase decoder, instantiated once for horizontal and once for vertical (vertical enable = horizontal wrap AND tick).

Verification
REQ-034 Reset held 3 cycles, then released -> pixelTick sequence 1,0,1,0...; pixelX steps 0->1 after 2 cycles.
REQ-035 Run one full line -> hSync low for exactly 192 inClk cycles, starting at pixelX=656; line period 1600 inClk cycles.
REQ-036 Run one full frame -> vSync low for lines 490-491 only; frame period 840000 inClk cycles; pixelX/pixelY never exceed 799/524.
REQ-037 Count videoOn over a frame -> high for 640x480x2 = 614400 inClk cycles; low whenever pixelX>=640 or pixelY>=480.
REQ-038 Reset asserted at pixelX=700, pixelY=300 -> next edge: all counters 0, hSync=1, vSync=1.
REQ-039 With VGA_SYNC_FRAME_PULSE_EN, run 2 frames -> frameStart pulses twice, each 1 cycle wide, 840000 cycles apart; without the macro -> frameStart constant 0.
